// File: rtl/getir_asamasi_if.sv
// Signal bundle between the fetch stage and its neighbours: control-status unit
// (ddb), L1 instruction cache (l1b), execute redirect (yrt) and decode (cyo).
interface getir_asamasi_if;
    // Cache handshake: fetch presents l1b_adr_o every cycle; l1b_bekle_i low is
    // "ready" and qualifies l1b_deger_i as the word at l1b_adr_o in that same cycle.
    // A redirect is a single-cycle valid (yrt_atlanan_ps_gecerli_i) with no ready.
    logic        ddb_durdur_i;
    logic        ddb_bosalt_i;
    logic        ddb_hazir_o;
    logic        ddb_yanlis_tahmin_o;
    logic        l1b_bekle_i;
    logic [31:0] l1b_deger_i;
    logic [31:1] l1b_adr_o;
    logic        yrt_atlanan_ps_gecerli_i;
    logic [31:1] yrt_atlanan_ps_i;
    logic [31:0] cyo_buyruk_o;
    logic [31:1] cyo_ps_artmis_o;
    logic [31:1] cyo_ps_o;

    modport master (
        input  ddb_durdur_i, ddb_bosalt_i, l1b_bekle_i, l1b_deger_i,
               yrt_atlanan_ps_gecerli_i, yrt_atlanan_ps_i,
        output ddb_hazir_o, ddb_yanlis_tahmin_o, l1b_adr_o,
               cyo_buyruk_o, cyo_ps_artmis_o, cyo_ps_o
    );

    modport slave (
        output ddb_durdur_i, ddb_bosalt_i, l1b_bekle_i, l1b_deger_i,
               yrt_atlanan_ps_gecerli_i, yrt_atlanan_ps_i,
        input  ddb_hazir_o, ddb_yanlis_tahmin_o, l1b_adr_o,
               cyo_buyruk_o, cyo_ps_artmis_o, cyo_ps_o
    );
endinterface

// File: rtl/getir_asamasi.sv
// RV32 instruction-fetch stage: PC register, cache address, fetch->decode register.
// Optional static BTFN prediction is enabled with the GETIR_STATIK_TAHMIN_EN macro.
module getir_asamasi #(
    parameter logic [31:0] BASLANGIC_PS = 32'h4000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    getir_asamasi_if.master bus
);
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:1] PS_RESET = BASLANGIC_PS[31:1];

    // All PC values are halfword indices (byte address bits [31:1]).
    logic [31:1] ps_q, ps_d;
    logic [31:1] ps_siradaki;
    logic [31:1] ps_tahmin;
    logic [31:0] cyo_buyruk_q, cyo_buyruk_d;
    logic [31:1] cyo_ps_q, cyo_ps_d;
    logic [31:1] cyo_ps_artmis_q, cyo_ps_artmis_d;

    assign ps_siradaki = ps_q + 31'd2;

`ifdef GETIR_STATIK_TAHMIN_EN
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [31:0] deger;
    logic [31:1] j_imm;
    logic [31:1] b_imm;

    assign deger = bus.l1b_deger_i;
    // Immediates are byte offsets with an implicit zero LSB, so [31:1] is the halfword offset.
    assign j_imm = {{11{deger[31]}}, deger[31], deger[19:12], deger[20], deger[30:21]};
    assign b_imm = {{19{deger[31]}}, deger[31], deger[7], deger[30:25], deger[11:8]};

    always_comb begin
        ps_tahmin = ps_siradaki;
        if (!bus.l1b_bekle_i) begin
            if (deger[6:0] == OP_JAL) begin
                ps_tahmin = ps_q + j_imm;
            end else if (deger[6:0] == OP_BRANCH && deger[31]) begin
                ps_tahmin = ps_q + b_imm;
            end
        end
    end
`else
    assign ps_tahmin = ps_siradaki;
`endif

    always_comb begin
        ps_d = ps_q;
        if (bus.yrt_atlanan_ps_gecerli_i) begin
            ps_d = bus.yrt_atlanan_ps_i;
        end else if (!bus.ddb_durdur_i && !bus.l1b_bekle_i) begin
            ps_d = ps_tahmin;
        end
    end

    // A redirect squashes the word fetched this cycle even while stalled.
    always_comb begin
        cyo_buyruk_d    = cyo_buyruk_q;
        cyo_ps_d        = cyo_ps_q;
        cyo_ps_artmis_d = cyo_ps_artmis_q;
        if (bus.ddb_bosalt_i || bus.yrt_atlanan_ps_gecerli_i) begin
            cyo_buyruk_d = NOP;
        end else if (bus.ddb_durdur_i) begin
            cyo_buyruk_d = cyo_buyruk_q;
        end else if (bus.l1b_bekle_i) begin
            cyo_buyruk_d = NOP;
        end else begin
            cyo_buyruk_d    = bus.l1b_deger_i;
            cyo_ps_d        = ps_q;
            cyo_ps_artmis_d = ps_siradaki;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ps_q            <= PS_RESET;
            cyo_buyruk_q    <= NOP;
            cyo_ps_q        <= '0;
            cyo_ps_artmis_q <= '0;
        end else begin
            ps_q            <= ps_d;
            cyo_buyruk_q    <= cyo_buyruk_d;
            cyo_ps_q        <= cyo_ps_d;
            cyo_ps_artmis_q <= cyo_ps_artmis_d;
        end
    end

    assign bus.l1b_adr_o           = ps_q;
    assign bus.ddb_hazir_o         = ~bus.l1b_bekle_i;
    assign bus.ddb_yanlis_tahmin_o = bus.yrt_atlanan_ps_gecerli_i;
    assign bus.cyo_buyruk_o        = cyo_buyruk_q;
    assign bus.cyo_ps_o            = cyo_ps_q;
    assign bus.cyo_ps_artmis_o     = cyo_ps_artmis_q;
endmodule

// File: tb/tb_getir_asamasi.sv
// Self-checking bench for getir_asamasi: directed vector table, hand sequences
// for prediction and asynchronous reset, then randomized traffic against a byte-address model.
module tb_getir_asamasi;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    getir_asamasi_if bus();

    getir_asamasi #(.BASLANGIC_PS(32'h4000_0000)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.master)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, wanted %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic d, input logic b, input logic k, input logic y,
                         input logic [31:1] yps, input logic [31:0] deg);
        bus.ddb_durdur_i             = d;
        bus.ddb_bosalt_i             = b;
        bus.l1b_bekle_i              = k;
        bus.yrt_atlanan_ps_gecerli_i = y;
        bus.yrt_atlanan_ps_i         = yps;
        bus.l1b_deger_i              = deg;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        d, b, k, y;
        logic [31:1] yps;
        logic [31:0] deg;
        logic [31:1] e_adr;
        logic [31:0] e_ins;
        logic [31:1] e_ps;
        logic [31:1] e_art;
    } vec_t;

    vec_t vecs[15];

    // ---------------- reference model (byte addresses) ----------------
    logic [31:0] m_ps, m_ins, m_pc, m_art;

    function automatic logic [31:0] pred_next(input logic [31:0] pc, input logic [31:0] w,
                                              input logic k);
        logic [20:0] jo;
        logic [12:0] bo;
        pred_next = pc + 32'd4;
`ifdef GETIR_STATIK_TAHMIN_EN
        jo = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        bo = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        if (!k && w[6:0] == 7'h6f) pred_next = pc + 32'($signed(jo));
        else if (!k && w[6:0] == 7'h63 && w[31]) pred_next = pc + 32'($signed(bo));
`else
        jo = '0;
        bo = '0;
        if (w[0] && k && jo[0] && bo[0]) pred_next = pc;
`endif
    endfunction

    task automatic model_reset();
        m_ps = 32'h4000_0000; m_ins = NOP; m_pc = '0; m_art = '0;
    endtask

    task automatic model_step(input logic d, input logic b, input logic k, input logic y,
                              input logic [31:1] yps, input logic [31:0] deg);
        logic [31:0] nps;
        if (y) nps = {yps, 1'b0};
        else if (d || k) nps = m_ps;
        else nps = pred_next(m_ps, deg, k);
        if (b || y) m_ins = NOP;
        else if (!d) begin
            if (k) m_ins = NOP;
            else begin m_ins = deg; m_pc = m_ps; m_art = m_ps + 32'd4; end
        end
        m_ps = nps;
    endtask

    task automatic rand_cycle();
        logic d, b, k, y;
        logic [31:1] yps;
        logic [31:0] deg;
        d   = ($urandom_range(0, 5) == 0);
        b   = ($urandom_range(0, 7) == 0);
        k   = ($urandom_range(0, 4) == 0);
        y   = ($urandom_range(0, 9) == 0);
        yps = 31'($urandom);
        deg = $urandom;
        if ($urandom_range(0, 3) == 0) deg[6:0] = ($urandom_range(0, 1) == 0) ? 7'h6f : 7'h63;
        drive(d, b, k, y, yps, deg);
        #1;
        chk("rnd_adr", {1'b0, bus.l1b_adr_o}, {1'b0, m_ps[31:1]});
        chk("rnd_hazir", {31'd0, bus.ddb_hazir_o}, {31'd0, ~k});
        chk("rnd_yanlis", {31'd0, bus.ddb_yanlis_tahmin_o}, {31'd0, y});
        model_step(d, b, k, y, yps, deg);
        @(posedge clk); #1;
        chk("rnd_ins", bus.cyo_buyruk_o, m_ins);
        chk("rnd_ps", {1'b0, bus.cyo_ps_o}, {1'b0, m_pc[31:1]});
        chk("rnd_art", {1'b0, bus.cyo_ps_artmis_o}, {1'b0, m_art[31:1]});
        @(negedge clk);
    endtask

    task automatic hand_cycle(input string nm, input logic y, input logic [31:1] yps,
                              input logic [31:0] deg, input logic [31:1] e_adr);
        drive(1'b0, 1'b0, 1'b0, y, yps, deg);
        @(posedge clk); #1;
        chk(nm, {1'b0, bus.l1b_adr_o}, {1'b0, e_adr});
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{0,0,0,0, 31'h0,         32'hf0f0_f0f0, 31'h2000_0002, 32'hf0f0_f0f0, 31'h2000_0000, 31'h2000_0002};
        vecs[1]  = '{0,0,0,0, 31'h0,         32'h1111_1111, 31'h2000_0004, 32'h1111_1111, 31'h2000_0002, 31'h2000_0004};
        vecs[2]  = '{0,0,0,1, 31'h7fff_8000, 32'h2222_2222, 31'h7fff_8000, NOP,           31'h2000_0002, 31'h2000_0004};
        vecs[3]  = '{0,1,0,0, 31'h0,         32'h3333_3333, 31'h7fff_8002, NOP,           31'h2000_0002, 31'h2000_0004};
        vecs[4]  = '{0,0,0,0, 31'h0,         32'h5555_5555, 31'h7fff_8004, 32'h5555_5555, 31'h7fff_8002, 31'h7fff_8004};
        vecs[5]  = '{1,0,0,0, 31'h0,         32'h6666_6666, 31'h7fff_8004, 32'h5555_5555, 31'h7fff_8002, 31'h7fff_8004};
        vecs[6]  = '{1,0,0,0, 31'h0,         32'h7777_7777, 31'h7fff_8004, 32'h5555_5555, 31'h7fff_8002, 31'h7fff_8004};
        vecs[7]  = '{1,1,0,0, 31'h0,         32'h0000_0000, 31'h7fff_8004, NOP,           31'h7fff_8002, 31'h7fff_8004};
        vecs[8]  = '{0,0,1,0, 31'h0,         32'h8888_8888, 31'h7fff_8004, NOP,           31'h7fff_8002, 31'h7fff_8004};
        vecs[9]  = '{0,0,1,0, 31'h0,         32'h8888_8888, 31'h7fff_8004, NOP,           31'h7fff_8002, 31'h7fff_8004};
        vecs[10] = '{0,0,1,0, 31'h0,         32'h8888_8888, 31'h7fff_8004, NOP,           31'h7fff_8002, 31'h7fff_8004};
        vecs[11] = '{0,0,0,0, 31'h0,         32'h9999_9999, 31'h7fff_8006, 32'h9999_9999, 31'h7fff_8004, 31'h7fff_8006};
        vecs[12] = '{1,0,1,1, 31'h7fff_fffe, 32'haaaa_aaaa, 31'h7fff_fffe, NOP,           31'h7fff_8004, 31'h7fff_8006};
        vecs[13] = '{0,0,0,0, 31'h0,         32'habcd_ef00, 31'h0000_0000, 32'habcd_ef00, 31'h7fff_fffe, 31'h0000_0000};
        vecs[14] = '{0,1,1,0, 31'h0,         32'h1234_5600, 31'h0000_0000, NOP,           31'h7fff_fffe, 31'h0000_0000};

        // Reset state, with clocks running and a cache wait showing through.
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 31'h0, 32'hf0f0_f0f0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_adr", {1'b0, bus.l1b_adr_o}, 32'h2000_0000);
        chk("rst_ins", bus.cyo_buyruk_o, NOP);
        chk("rst_ps", {1'b0, bus.cyo_ps_o}, 32'h0);
        chk("rst_art", {1'b0, bus.cyo_ps_artmis_o}, 32'h0);
        chk("rst_hazir", {31'd0, bus.ddb_hazir_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].d, vecs[i].b, vecs[i].k, vecs[i].y, vecs[i].yps, vecs[i].deg);
            #1;
            chk($sformatf("v%0d_hazir", i), {31'd0, bus.ddb_hazir_o}, {31'd0, ~vecs[i].k});
            chk($sformatf("v%0d_yanlis", i), {31'd0, bus.ddb_yanlis_tahmin_o}, {31'd0, vecs[i].y});
            @(posedge clk); #1;
            chk($sformatf("v%0d_adr", i), {1'b0, bus.l1b_adr_o}, {1'b0, vecs[i].e_adr});
            chk($sformatf("v%0d_ins", i), bus.cyo_buyruk_o, vecs[i].e_ins);
            chk($sformatf("v%0d_ps", i), {1'b0, bus.cyo_ps_o}, {1'b0, vecs[i].e_ps});
            chk($sformatf("v%0d_art", i), {1'b0, bus.cyo_ps_artmis_o}, {1'b0, vecs[i].e_art});
            @(negedge clk);
        end

        // Prediction: backward branch, JAL, forward branch.
        hand_cycle("pr_redirect", 1'b1, 31'h2000_0010, 32'h0000_0000, 31'h2000_0010);
`ifdef GETIR_STATIK_TAHMIN_EN
        hand_cycle("pr_bwd_br", 1'b0, 31'h0, 32'hfe00_0ee3, 31'h2000_000e);
        hand_cycle("pr_jal",    1'b0, 31'h0, 32'h0080_006f, 31'h2000_0012);
        hand_cycle("pr_fwd_br", 1'b0, 31'h0, 32'h0000_0463, 31'h2000_0014);
`else
        hand_cycle("pr_bwd_br", 1'b0, 31'h0, 32'hfe00_0ee3, 31'h2000_0012);
        hand_cycle("pr_jal",    1'b0, 31'h0, 32'h0080_006f, 31'h2000_0014);
        hand_cycle("pr_fwd_br", 1'b0, 31'h0, 32'h0000_0463, 31'h2000_0016);
`endif

        // Asynchronous reset in the middle of a cycle, no clock edge involved.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_adr", {1'b0, bus.l1b_adr_o}, 32'h2000_0000);
        chk("arst_ins", bus.cyo_buyruk_o, NOP);
        chk("arst_ps", {1'b0, bus.cyo_ps_o}, 32'h0);
        chk("arst_art", {1'b0, bus.cyo_ps_artmis_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int n = 0; n < 400; n++) rand_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
